// File: rtl/turfio_pkg.sv
// Shared definitions for the TURFIO CIN transmit path: link words, framing
// constants and the word-boundary state type.
package turfio_pkg;

  localparam logic [31:0] TRAIN_VALUE_DEF  = 32'hA55A6996;
  localparam logic [31:0] IDLE_VALUE_DEF   = 32'h00000000;
  localparam int          NIBBLES_PER_WORD = 8;
  localparam logic [2:0]  NIB_LAST         = 3'(NIBBLES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    TRAIN = 2'd2
  } cin_state_t;

  // Advance the transmit shift register by one nibble, MSB first.
  function automatic logic [31:0] shift_nibble(input logic [31:0] word);
    return {word[27:0], 4'h0};
  endfunction

endpackage

// File: rtl/turfio_cin_cmd_fifo.sv
// First-word-fall-through command FIFO on a small distributed RAM; the ready
// flag is registered from the next-cycle occupancy so it equals !full.
module turfio_cin_cmd_fifo #(
  parameter int ADDR_BITS = 2,
  parameter int WIDTH     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_ready
);

  localparam int                   DEPTH    = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]   CNT_FULL = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_count;
  logic                 r_ready;
  logic [ADDR_BITS:0]   w_count_nxt;
  logic                 w_full;
  logic                 w_do_push;
  logic                 w_do_pop;

  // A push into a full FIFO is legal when the same cycle pops a slot free.
  always_comb begin
    w_full      = (r_count == CNT_FULL);
    w_do_pop    = i_pop && (r_count != '0);
    w_do_push   = i_push && (!w_full || w_do_pop);
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Storage write port.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and registered ready.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != CNT_FULL);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_ready = r_ready;

endmodule

// File: rtl/turfio_cin_tx_framer.sv
// CIN link transmitter: queues 32-bit commands and emits them as MSB-first
// nibbles, interleaving training and idle words under a word-boundary FSM.
module turfio_cin_tx_framer
  import turfio_pkg::*;
#(
  parameter logic [31:0] TRAIN_VALUE    = TRAIN_VALUE_DEF,
  parameter logic [31:0] IDLE_VALUE     = IDLE_VALUE_DEF,
  parameter int          FIFO_ADDR_BITS = 2
) (
  input  logic        aclk_i,
  input  logic        aresetn_i,
  input  logic        ce_i,
  input  logic        sync_i,
  input  logic        train_i,
  input  logic [31:0] cmd_data_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [3:0]  cin_o,
  output logic        word_start_o,
  output logic        train_active_o,
  output logic        sync_err_o,
  output logic        cmd_sent_o
);

  logic        r_rst_meta;
  logic        r_rst_sync;
  logic        w_rst_n;
  cin_state_t  r_state;
  cin_state_t  w_state_nxt;
  cin_state_t  w_sel_state;
  logic [2:0]  r_nib;
  logic [31:0] r_shift;
  logic [31:0] w_word;
  logic [31:0] w_fifo_data;
  logic        r_sync_pend;
  logic        w_sync_req;
  logic        w_boundary;
  logic        w_pop;
  logic        w_push;
  logic        w_fifo_empty;
  logic        w_fifo_ready;
  logic [3:0]  r_cin;
  logic        r_word_start;
  logic        r_train_active;
  logic        r_sync_err;
  logic        r_cmd_sent;

  // Reset asserts asynchronously but releases two clocks after aresetn_i rises.
  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n    = r_rst_sync;
  assign w_push     = cmd_valid_i & w_fifo_ready;
  assign w_sync_req = sync_i | r_sync_pend;
  assign w_boundary = ce_i & ((r_nib == NIB_LAST) | w_sync_req);

  turfio_cin_cmd_fifo #(
    .ADDR_BITS (FIFO_ADDR_BITS),
    .WIDTH     (32)
  ) u_cmd_fifo (
    .i_clk   (aclk_i),
    .i_rst_n (w_rst_n),
    .i_push  (w_push),
    .i_data  (cmd_data_i),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_ready (w_fifo_ready)
  );

  // Next word choice; training always wins, and leaving training costs one idle word.
  always_comb begin
    w_sel_state = IDLE;
    w_word      = IDLE_VALUE;
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    if (train_i) begin
      w_sel_state = TRAIN;
    end else if ((r_state != TRAIN) && !w_fifo_empty) begin
      w_sel_state = RUN;
    end else begin
      w_sel_state = IDLE;
    end
    case (w_sel_state)
      TRAIN:   w_word = TRAIN_VALUE;
      RUN:     w_word = w_fifo_data;
      IDLE:    w_word = IDLE_VALUE;
      default: w_word = IDLE_VALUE;
    endcase
    if (w_boundary) begin
      w_state_nxt = w_sel_state;
      w_pop       = (w_sel_state == RUN);
    end else begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge aclk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Framing datapath: nibble counter, shift register and registered outputs.
  always_ff @(posedge aclk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_nib          <= NIB_LAST;
      r_shift        <= 32'h00000000;
      r_sync_pend    <= 1'b0;
      r_cin          <= 4'h0;
      r_word_start   <= 1'b0;
      r_train_active <= 1'b0;
      r_sync_err     <= 1'b0;
      r_cmd_sent     <= 1'b0;
    end else begin
      r_cmd_sent <= 1'b0;
      if (ce_i) begin
        r_sync_pend <= 1'b0;
        if (w_boundary) begin
          r_nib          <= 3'd0;
          r_shift        <= w_word;
          r_cin          <= w_word[31:28];
          r_word_start   <= 1'b1;
          r_train_active <= (w_sel_state == TRAIN);
          r_cmd_sent     <= (w_sel_state == RUN);
          // A realign that cuts a word short is remembered until reset.
          if (w_sync_req && (r_nib != NIB_LAST)) begin
            r_sync_err <= 1'b1;
          end
        end else begin
          r_nib        <= r_nib + 3'd1;
          r_shift      <= shift_nibble(r_shift);
          r_cin        <= r_shift[27:24];
          r_word_start <= 1'b0;
        end
      end else if (sync_i) begin
        r_sync_pend <= 1'b1;
      end
    end
  end

  assign cmd_ready_o    = w_fifo_ready;
  assign cin_o          = r_cin;
  assign word_start_o   = r_word_start;
  assign train_active_o = r_train_active;
  assign sync_err_o     = r_sync_err;
  assign cmd_sent_o     = r_cmd_sent;

endmodule

// File: tb/tb_turfio_cin_tx_framer.sv
// Self-checking bench for turfio_cin_tx_framer: vector table for training and a
// single command, then directed multi-cycle sequences and a randomised scoreboard run.
module tb_turfio_cin_tx_framer;

  logic        aclk_i;
  logic        aresetn_i;
  logic        ce_i;
  logic        sync_i;
  logic        train_i;
  logic [31:0] cmd_data_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [3:0]  cin_o;
  logic        word_start_o;
  logic        train_active_o;
  logic        sync_err_o;
  logic        cmd_sent_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] rx_q [$];
  logic [31:0] exp_q [$];
  int          sent_cyc [$];

  typedef struct {
    logic        ce;
    logic        train;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  cin;
    logic        ws;
    logic        ta;
    logic        cs;
    logic        rdy;
    logic        err;
  } vec_t;

  vec_t tbl [$];

  turfio_cin_tx_framer dut (
    .aclk_i         (aclk_i),
    .aresetn_i      (aresetn_i),
    .ce_i           (ce_i),
    .sync_i         (sync_i),
    .train_i        (train_i),
    .cmd_data_i     (cmd_data_i),
    .cmd_valid_i    (cmd_valid_i),
    .cmd_ready_o    (cmd_ready_o),
    .cin_o          (cin_o),
    .word_start_o   (word_start_o),
    .train_active_o (train_active_o),
    .sync_err_o     (sync_err_o),
    .cmd_sent_o     (cmd_sent_o)
  );

  initial begin
    aclk_i = 1'b0;
    forever #5 aclk_i = ~aclk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Receiver model: rebuilds command words from nibbles, starting on cmd_sent_o.
  logic        mon_ce;
  logic        mon_coll = 1'b0;
  int          mon_nibs = 0;
  logic [31:0] mon_acc  = 32'h0;
  always begin
    @(posedge aclk_i);
    mon_ce = ce_i;
    cyc++;
    #2;
    if (!aresetn_i) begin
      mon_coll = 1'b0;
    end else if (mon_ce) begin
      if (word_start_o) begin
        mon_coll = cmd_sent_o;
        mon_nibs = 1;
        mon_acc  = {28'h0, cin_o};
      end else if (mon_coll) begin
        mon_acc  = {mon_acc[27:0], cin_o};
        mon_nibs++;
      end
      if (mon_coll && mon_nibs == 8) begin
        rx_q.push_back(mon_acc);
        mon_coll = 1'b0;
      end
    end
    if (cmd_sent_o) sent_cyc.push_back(cyc);
  end

  task automatic step();
    @(posedge aclk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] pack_out();
    return {cin_o, word_start_o, train_active_o, cmd_sent_o, cmd_ready_o, sync_err_o};
  endfunction

  function automatic vec_t mk(input logic ce, input logic train, input logic valid,
                              input logic [31:0] data, input logic [3:0] cin,
                              input logic ws, input logic ta, input logic cs);
    vec_t v;
    v.ce = ce; v.train = train; v.valid = valid; v.data = data;
    v.cin = cin; v.ws = ws; v.ta = ta; v.cs = cs; v.rdy = 1'b1; v.err = 1'b0;
    return v;
  endfunction

  task automatic wait_ws(input string nm);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      seen = word_start_o;
    end
    check(nm, {31'd0, seen}, 32'd1);
  endtask

  logic [3:0]  tn [8] = '{4'hA, 4'h5, 4'h5, 4'hA, 4'h6, 4'h9, 4'h9, 4'h6};
  logic [31:0] bw [5] = '{32'hDEADBEEF, 32'h01234567, 32'hCAFEF00D, 32'h89ABCDEF, 32'h5A5AA5A5};

  initial begin
    logic accepted;
    logic rdy_before;
    logic done;
    int   k;

    aresetn_i = 1'b0; ce_i = 1'b0; sync_i = 1'b0; train_i = 1'b0;
    cmd_data_i = 32'h0; cmd_valid_i = 1'b0;

    // ---- vector table ----
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, tn[i % 8], (i % 8) == 0, 1'b1, 1'b0));
    for (int j = 1; j < 8; j++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, tn[j], 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'h12345678, 4'h0, 1'b0, 1'b0, 1'b0));
    for (int j = 2; j < 8; j++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    for (int j = 0; j < 8; j++)
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 4'(j + 1), j == 0, 1'b0, j == 0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0));

    // ---- reset ----
    step(); step();
    check("reset_outputs", 32'(pack_out()), 32'h0);
    aresetn_i = 1'b1;
    step(); step();
    check("ready_during_release", {31'd0, cmd_ready_o}, 32'd0);
    step(); step();
    check("ready_after_release", {31'd0, cmd_ready_o}, 32'd1);
    check("idle_after_release", 32'(pack_out()), 32'h002);

    // ---- table ----
    rx_q.delete();
    foreach (tbl[i]) begin
      ce_i = tbl[i].ce; train_i = tbl[i].train;
      cmd_valid_i = tbl[i].valid; cmd_data_i = tbl[i].data;
      step();
      check($sformatf("vec%0d", i), 32'(pack_out()),
            32'({tbl[i].cin, tbl[i].ws, tbl[i].ta, tbl[i].cs, tbl[i].rdy, tbl[i].err}));
    end
    check("single_cmd_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("single_cmd_word", rx_q[0], 32'h12345678);

    // ---- five pushes with ce low, then back-to-back drain ----
    rx_q.delete(); sent_cyc.delete(); exp_q.delete();
    ce_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid_i = 1'b1; cmd_data_i = bw[i]; exp_q.push_back(bw[i]);
      step();
    end
    check("ready_low_when_full", {31'd0, cmd_ready_o}, 32'd0);
    cmd_data_i = bw[4]; exp_q.push_back(bw[4]);
    step(); step();
    check("ready_stays_low", {31'd0, cmd_ready_o}, 32'd0);
    ce_i = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      rdy_before = cmd_ready_o;
      step();
      if (rdy_before) begin
        accepted = 1'b1;
        cmd_valid_i = 1'b0;
      end
    end
    check("fifth_accepted", {31'd0, accepted}, 32'd1);
    for (int i = 0; i < 100 && rx_q.size() < 5; i++) step();
    check("b2b_count", rx_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++) check($sformatf("b2b_word%0d", i), rx_q[i], exp_q[i]);
    for (int i = 1; i < 5 && i < sent_cyc.size(); i++)
      check($sformatf("b2b_gap%0d", i), sent_cyc[i] - sent_cyc[i-1], 32'd8);

    // ---- train asserted mid command word ----
    rx_q.delete();
    ce_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_data_i = 32'hC0C0C0C0; step();
    cmd_data_i = 32'hC1C1C1C1; step();
    cmd_valid_i = 1'b0;
    ce_i = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      done = cmd_sent_o;
    end
    check("train_mid_first_sent", {31'd0, done}, 32'd1);
    step(); step(); step();
    train_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("train_after_cmd", {26'd0, cin_o, word_start_o, train_active_o}, {26'd0, 4'hA, 1'b1, 1'b1});
    train_i = 1'b0;
    for (int i = 0; i < 60 && rx_q.size() < 2; i++) step();
    check("train_mid_count", rx_q.size(), 32'd2);
    if (rx_q.size() > 0) check("train_mid_word0", rx_q[0], 32'hC0C0C0C0);
    if (rx_q.size() > 1) check("train_mid_word1", rx_q[1], 32'hC1C1C1C1);

    // ---- sync held across ce low, landing mid-word ----
    wait_ws("sync_held_align");
    step(); step();
    ce_i = 1'b0; sync_i = 1'b1; step();
    check("sync_pending_hold", {30'd0, word_start_o, sync_err_o}, 32'd0);
    sync_i = 1'b0; step();
    ce_i = 1'b1; step();
    check("sync_held_boundary", {30'd0, word_start_o, sync_err_o}, 32'd3);

    // ---- reset in the middle of a training word ----
    train_i = 1'b1;
    wait_ws("pre_reset_align");
    step(); step();
    check("pre_reset_word", {27'd0, cin_o, train_active_o}, {27'd0, 4'h5, 1'b1});
    aresetn_i = 1'b0;
    #1;
    check("async_reset_outputs", 32'(pack_out()), 32'h0);
    step(); step(); step();
    train_i = 1'b0;
    aresetn_i = 1'b1;
    step(); step(); step(); step();
    check("ready_after_rereset", {31'd0, cmd_ready_o}, 32'd1);

    // ---- sync on the natural boundary, then mid-word ----
    wait_ws("sync7_align");
    for (int i = 0; i < 7; i++) step();
    sync_i = 1'b1; step(); sync_i = 1'b0;
    check("sync_at_nib7", {30'd0, word_start_o, sync_err_o}, 32'd2);
    for (int i = 0; i < 4; i++) step();
    sync_i = 1'b1; step(); sync_i = 1'b0;
    check("sync_at_nib4", {30'd0, word_start_o, sync_err_o}, 32'd3);

    // ---- ce one cycle in three, random pushes and training ----
    rx_q.delete(); exp_q.delete();
    cmd_valid_i = 1'b0;
    k = 0;
    for (int n = 0; n < 900; n++) begin
      ce_i = (k % 3 == 0);
      if ($urandom_range(0, 63) == 0) train_i = ~train_i;
      if (!cmd_valid_i || cmd_ready_o) begin
        cmd_valid_i = ($urandom_range(0, 3) == 0);
        cmd_data_i  = $urandom;
      end
      if (cmd_valid_i && cmd_ready_o) exp_q.push_back(cmd_data_i);
      step();
      k++;
    end
    cmd_valid_i = 1'b0; train_i = 1'b0;
    for (int n = 0; n < 2000 && rx_q.size() < exp_q.size(); n++) begin
      ce_i = (k % 3 == 0);
      step();
      k++;
    end
    for (int n = 0; n < 48; n++) begin
      ce_i = (k % 3 == 0);
      step();
      k++;
    end
    check("rand_count", rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("rand_word%0d", i), rx_q[i], exp_q[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
